sseg_scroll_driver: RTL and testbench
=====================================

# sseg_scroll_driver

Downstream display stage for the metro station board. Accepts a 12-character, 7-segment-encoded station name through a valid/ready load port, holds the first four characters, then rotates the message left one character per scroll step. It time-multiplexes a 4-digit common-anode display. The station controller only decides *what* to show; this block owns scrolling, digit scanning and blanking.

## Interface
- `SCROLL_DIV`, default 100_000_000: clock cycles per scroll step (≥2).
- `HOLD_STEPS`, default 1: scroll steps the first window is held after a load before rotation starts (≥0).
- `SCAN_BITS`, default 18: refresh counter width; digit select = `cnt[SCAN_BITS-1:SCAN_BITS-2]` (≥2).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_valid` in 1: new message offered.
- `load_msg` in 84: 12 chars × 7 bits, char 0 = `[83:77]`, char 11 = `[6:0]`, segment bit 1 = off.
- `load_ready` out 1: block can accept a message.
- `blank` in 1: force display dark; state keeps running.
- `step` out 1: one-cycle pulse on each scroll step.
- `busy` out 1: high in HOLD or SCROLL.
- `sseg` out 7: segment drive, active-low.
- `an` out 4: digit enables, active-low.
- `dp` out 1: decimal point, constant 1 (off).

## Operation
- Storage: 12 × 7-bit character buffer and a 4-bit head pointer `head` (0..11).
- Accept = `load_valid && load_ready`. On accept, in the same edge:
  - buffer ← `load_msg`, `head` ← 0;
  - prescaler ← 0, hold counter ← `HOLD_STEPS`;
  - state → HOLD, or SCROLL when `HOLD_STEPS`=0.
- `load_ready` = 1 in every state after reset. Reload mid-scroll is legal and restarts from char 0.
- Prescaler counts 0..`SCROLL_DIV`-1 in HOLD and SCROLL. At terminal count it wraps to 0 and raises `step` for that cycle. In IDLE it is held at 0.
- FSM:
  - IDLE: no message loaded. Display dark. Leaves only on accept.
  - HOLD: on each `step`, decrement the hold counter. When a `step` occurs with counter = 1, go to SCROLL. `head` is unchanged.
  - SCROLL: on each `step`, `head` ← (`head`+1) mod 12, so 11 wraps to 0. Stays in SCROLL indefinitely.
- Simultaneous accept and `step`: the accept wins. The step's head/hold update is discarded, but the `step` pulse is still output.
- Display window: digit d (d=0..3) shows char (`head`+d) mod 12.
  - d=0 drives `an`=1110, d=1 → 1101, d=2 → 1011, d=3 → 0111.
  - Wrap example: `head`=10 shows chars 10, 11, 0, 1.
- Dark display is `an`=1111 and `sseg`=1111111. It is driven when state is IDLE or `blank`=1. `blank` does not freeze the prescaler, the hold counter or `head`.

## Timing
- Reset values: `an`=1111, `sseg`=1111111, `dp`=1, `step`=0, `busy`=0, `load_ready`=0 while `rst_n`=0. `load_ready` is 1 from the first edge after release. State = IDLE, `head`=0, all counters 0.
- Reset asserted mid-scroll: outputs go to reset values immediately (asynchronous). The buffer contents are don't-care; IDLE guarantees the display stays dark.
- The refresh counter free-runs in all non-reset states.
- `an` and `sseg` are registered: they reflect the refresh counter, `head`, buffer, state and `blank` as sampled one clock earlier.
  - First lit digit: the second edge after accept (accept edge + output register).
  - `blank` rising or falling: takes effect on the display 1 cycle later.
- `step` is registered high for exactly 1 cycle, `SCROLL_DIV` cycles apart. The first step comes `SCROLL_DIV` cycles after the accept edge.
- With `HOLD_STEPS`=H, the first `head` change occurs at step H+1.
- `busy` rises on the accept edge and never falls except by reset.

## Test plan
All scenarios use `SCROLL_DIV`=4, `SCAN_BITS`=4, `HOLD_STEPS`=2, with chars loaded as codes 0x01..0x0C.
- **Reset:** release `rst_n` with no load → `an`=1111, `sseg`=7F, `dp`=1, `busy`=0, `load_ready`=1 for 200 cycles; `step` never pulses.
- **Load and scan:** load once → 2 cycles later the scan cycles `an` 1110/1101/1011/0111 with `sseg` 01/02/03/04. `step` pulses every 4 cycles; `head` stays 0 for steps 1–2, then is 1 after step 3 (window 02..05).
- **Wrap:** run 12 steps past hold → `head` goes 11→0. At `head`=10 the window is 0B, 0C, 01, 02.
- **Reload:** reload on the same cycle as a step while `head`=5 → `head`=0 and the new message shows. Hold restarts, and the next head change comes 3 steps later.
- **Blank:** `blank`=1 for 10 steps → display dark 1 cycle after assertion, while `head` still advances 10. On release, the display resumes at the advanced window.
- **Async reset mid-scroll:** drop `rst_n` between clock edges mid-scroll → `an`=1111 immediately. After release the block is in IDLE and stays dark until the next load.

Source files
------------

// File: rtl/sseg_scroll_driver.sv
// Scrolling driver for a 4-digit common-anode 7-segment display.
// Holds a 12-character message and shows a 4-character window onto it.
// After the hold period, the window rotates left one character per scroll step.
module sseg_scroll_driver #(
  parameter int SCROLL_DIV = 100_000_000,
  parameter int HOLD_STEPS = 1,
  parameter int SCAN_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [83:0] load_msg,
  output logic        load_ready,
  input  logic        blank,
  output logic        step,
  output logic        busy,
  output logic [6:0]  sseg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int PW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int HW = $clog2(HOLD_STEPS + 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCROLL_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_STEPS);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t               state;
  logic [6:0]           char_buf [12];
  logic [3:0]           head;
  logic [PW-1:0]        presc;
  logic [HW-1:0]        hold_cnt;
  logic [SCAN_BITS-1:0] scan_cnt;

  logic       accept;
  logic       tick;
  logic [1:0] digit;
  logic [4:0] idx_sum;
  logic [3:0] char_idx;

  assign accept = load_valid && load_ready;
  assign tick   = (state != IDLE) && (presc == PRESC_LAST);
  assign digit  = scan_cnt[SCAN_BITS-1 -: 2];

  // Window position for the digit currently being scanned, wrapped modulo 12.
  assign idx_sum  = {1'b0, head} + {3'b000, digit};
  assign char_idx = (idx_sum >= 5'd12) ? 4'(idx_sum - 5'd12) : idx_sum[3:0];

  assign busy = (state != IDLE);
  assign dp   = 1'b1;

  // Message buffer: contents only matter once a load has moved us out of IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 12; i++) begin
        char_buf[i] <= load_msg[83 - 7*i -: 7];
      end
    end
  end

  // Control FSM: load handling, scroll prescaler, hold countdown and head rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      head       <= 4'd0;
      presc      <= '0;
      hold_cnt   <= '0;
      step       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      load_ready <= 1'b1;
      step       <= tick;
      if (accept) begin
        head     <= 4'd0;
        presc    <= '0;
        hold_cnt <= HOLD_INIT;
        state    <= (HOLD_STEPS == 0) ? SCROLL : HOLD;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
          end
          HOLD: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == HOLD_ONE) begin
                state <= SCROLL;
              end
            end
          end
          SCROLL: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              head <= (head == 4'd11) ? 4'd0 : head + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Free-running refresh counter; its top two bits pick the scanned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Registered display drive; dark while idle or blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= 4'b1111;
      sseg <= 7'b1111111;
    end else if (state == IDLE || blank) begin
      an   <= 4'b1111;
      sseg <= 7'b1111111;
    end else begin
      an   <= ~(4'b0001 << digit);
      sseg <= char_buf[char_idx];
    end
  end

endmodule

// File: tb/tb_sseg_scroll_driver.sv
// Self-checking bench for sseg_scroll_driver.
// A cycle model pushes expected outputs into a queue on every clock edge.
// The queue is popped and compared on the following falling edge.
module tb_sseg_scroll_driver;

  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int SB   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [83:0] load_msg = '0;
  logic        blank = 1'b0;
  logic        load_ready;
  logic        step;
  logic        busy;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        dp;

  sseg_scroll_driver #(
    .SCROLL_DIV (DIV),
    .HOLD_STEPS (HOLD),
    .SCAN_BITS  (SB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_msg   (load_msg),
    .load_ready (load_ready),
    .blank      (blank),
    .step       (step),
    .busy       (busy),
    .sseg       (sseg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [83:0] make_msg(input logic [6:0] base);
    logic [83:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) begin
      m[83 - 7*i -: 7] = base + 7'(i);
    end
    return m;
  endfunction

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       step;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  int         m_state;
  int         m_head;
  int         m_presc;
  int         m_hold;
  int         m_cnt;
  int         m_digit;
  bit         m_ready;
  bit         m_acc;
  bit         m_tick;
  logic [6:0] m_buf [12];
  exp_t       m_exp;
  exp_t       cmp_exp;

  // Behavioural model of the display driver, advanced on every rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_head  = 0;
      m_presc = 0;
      m_hold  = 0;
      m_cnt   = 0;
      m_ready = 1'b0;
      exp_q.delete();
    end else begin
      m_acc   = load_valid && m_ready;
      m_tick  = (m_state != 0) && (m_presc == DIV - 1);
      m_digit = (m_cnt >> (SB - 2)) & 3;
      if (m_state == 0 || blank) begin
        m_exp.an   = 4'hF;
        m_exp.sseg = 7'h7F;
      end else begin
        m_exp.an   = 4'hF ^ (4'h1 << m_digit);
        m_exp.sseg = m_buf[(m_head + m_digit) % 12];
      end
      m_exp.step = m_tick;
      m_cnt      = (m_cnt + 1) % (1 << SB);
      m_ready    = 1'b1;
      if (m_acc) begin
        for (int i = 0; i < 12; i++) m_buf[i] = load_msg[83 - 7*i -: 7];
        m_head  = 0;
        m_presc = 0;
        m_hold  = HOLD;
        m_state = (HOLD == 0) ? 2 : 1;
      end else if (m_state != 0) begin
        m_presc = m_tick ? 0 : m_presc + 1;
        if (m_tick) begin
          if (m_state == 1) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_state = 2;
          end else begin
            m_head = (m_head + 1) % 12;
          end
        end
      end
      m_exp.busy  = (m_state != 0);
      m_exp.ready = m_ready;
      exp_q.push_back(m_exp);
    end
  end

  // Scoreboard: compare DUT outputs with the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      checkOutput("sb_an", 32'(an), 32'(cmp_exp.an));
      checkOutput("sb_sseg", 32'(sseg), 32'(cmp_exp.sseg));
      checkOutput("sb_ctrl", 32'({step, busy, load_ready, dp}),
                  32'({cmp_exp.step, cmp_exp.busy, cmp_exp.ready, 1'b1}));
    end
  end

  task automatic applyStimulus(input logic [83:0] msg);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_msg   = msg;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_step(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step && n < 3 * DIV);
    if (!step) checkOutput({tag, "_timeout"}, 32'(step), 32'd1);
  endtask

  int n;
  int steps_seen;
  int bad;
  int exp_head;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_sseg", 32'(sseg), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'd1);
    checkOutput("rst_step", 32'(step), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(load_ready), 32'd0);
    rst_n = 1'b1;

    // Idle with no load: dark, ready, no steps
    steps_seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (step) steps_seen++;
    end
    checkOutput("idle_steps", 32'(steps_seen), 32'd0);
    checkOutput("idle_ready", 32'(load_ready), 32'd1);
    checkOutput("idle_an", 32'(an), 32'hF);

    // Load and scan through hold, rotation and wrap
    applyStimulus(make_msg(7'h01));
    checkOutput("busy_on_accept", 32'(busy), 32'd1);
    wait_step("first_step", n);
    checkOutput("first_step_latency", 32'(n), 32'(DIV));
    checkOutput("head_step1", 32'(dut.head), 32'd0);
    for (int k = 2; k <= 16; k++) begin
      wait_step($sformatf("step%0d", k), n);
      checkOutput($sformatf("step_period_%0d", k), 32'(n), 32'(DIV));
      exp_head = (k <= HOLD) ? 0 : (k - HOLD) % 12;
      checkOutput($sformatf("head_step%0d", k), 32'(dut.head), 32'(exp_head));
    end

    // Reload on the same edge as a step while head is 5
    for (int k = 0; k < 12 && dut.head != 4'd5; k++) wait_step("seek5", n);
    checkOutput("reach_head5", 32'(dut.head), 32'd5);
    repeat (DIV - 1) begin
      @(posedge clk); #1;
    end
    load_valid = 1'b1;
    load_msg   = make_msg(7'h11);
    @(posedge clk); #1;
    load_valid = 1'b0;
    checkOutput("reload_step", 32'(step), 32'd1);
    checkOutput("reload_head", 32'(dut.head), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      wait_step($sformatf("rl_step%0d", k), n);
      checkOutput($sformatf("rl_head%0d", k), 32'(dut.head), (k == 3) ? 32'd1 : 32'd0);
    end

    // Blank for 10 steps: dark display, head keeps moving
    blank = 1'b1;
    @(posedge clk); #1;
    checkOutput("blank_an", 32'(an), 32'hF);
    checkOutput("blank_sseg", 32'(sseg), 32'h7F);
    for (int k = 0; k < 10; k++) wait_step("blank_step", n);
    checkOutput("blank_head", 32'(dut.head), 32'd11);
    blank = 1'b0;
    @(posedge clk); #1;
    checkOutput("unblank_lit", 32'(an != 4'hF), 32'd1);

    // Asynchronous reset between clock edges
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_an", 32'(an), 32'hF);
    checkOutput("arst_sseg", 32'(sseg), 32'h7F);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_step", 32'(step), 32'd0);
    checkOutput("arst_ready", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || an !== 4'hF || step !== 1'b0) bad++;
    end
    checkOutput("post_reset_dark", 32'(bad), 32'd0);

    // Fresh load after reset
    applyStimulus(make_msg(7'h21));
    wait_step("post_reset_step", n);
    checkOutput("post_reset_latency", 32'(n), 32'(DIV));
    repeat (20) @(posedge clk);

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
